// File: rtl/pingpong_pkg.sv
// Shared constants for the ping-pong buffer write path: scheduler state
// encoding and buffer indices.
package pingpong_pkg;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t IDLE  = 2'd0;
  localparam sched_state_t WAIT  = 2'd1;
  localparam sched_state_t WRITE = 2'd2;

  localparam logic BUF0 = 1'b0;
  localparam logic BUF1 = 1'b1;

endpackage

// File: rtl/pingpong_wr_sched.sv
// Write-side ping-pong scheduler: steers one input stream into two FIFO write
// ports in alternating bursts of BURST_LEN words, gated by each buffer's prog_full.
module pingpong_wr_sched
  import pingpong_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int BURST_LEN = 256,
  parameter int CNT_W     = 16
) (
  input  logic                 wr_clk,
  input  logic                 rst,
  input  logic                 sched_en,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 in_ready,
  input  logic                 fifo0_full,
  input  logic                 fifo1_full,
  input  logic                 fifo0_prog_full,
  input  logic                 fifo1_prog_full,
  output logic                 fifo0_wr_en,
  output logic                 fifo1_wr_en,
  output logic [DATA_SIZE-1:0] fifo_din,
  output logic                 sel,
  output logic                 burst_done,
  output logic                 burst_buf,
  output logic [CNT_W-1:0]     burst_cnt,
  output logic                 busy
);

  localparam int             WC_W     = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam logic [WC_W-1:0] LAST_IDX = WC_W'(BURST_LEN - 1);

  sched_state_t     r_state;
  sched_state_t     w_next_state;
  logic             r_sel;
  logic [WC_W-1:0]  r_word_cnt;
  logic             r_burst_done;
  logic             r_burst_buf;
  logic [CNT_W-1:0] r_burst_cnt;

  logic w_full_sel;
  logic w_pfull_sel;
  logic w_pfull_alt;
  logic w_in_ready;
  logic w_accept;
  logic w_last;

  assign w_full_sel  = (r_sel == BUF1) ? fifo1_full      : fifo0_full;
  assign w_pfull_sel = (r_sel == BUF1) ? fifo1_prog_full : fifo0_prog_full;
  assign w_pfull_alt = (r_sel == BUF1) ? fifo0_prog_full : fifo1_prog_full;

  // State register and burst bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sel        <= BUF0;
      r_word_cnt   <= '0;
      r_burst_done <= 1'b0;
      r_burst_buf  <= BUF0;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_next_state;
      r_burst_done <= w_last;
      if (w_accept) begin
        r_word_cnt <= w_last ? '0 : r_word_cnt + WC_W'(1);
      end
      if (w_last) begin
        r_sel       <= ~r_sel;
        r_burst_buf <= r_sel;
        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic; a buffer committed in WAIT is not released by sched_en.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (sched_en) w_next_state = w_pfull_sel ? WAIT : WRITE;
      WAIT:    if (!w_pfull_sel) w_next_state = WRITE;
      WRITE: begin
        if (w_last) begin
          if (!sched_en)        w_next_state = IDLE;
          else if (w_pfull_alt) w_next_state = WAIT;
          else                  w_next_state = WRITE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Zero-latency write path; rst masks the handshake before state has reloaded.
  always_comb begin
    w_in_ready  = (r_state == WRITE) && !rst && !w_full_sel;
    w_accept    = in_valid && w_in_ready;
    w_last      = w_accept && (r_word_cnt == LAST_IDX);
    fifo0_wr_en = w_accept && (r_sel == BUF0);
    fifo1_wr_en = w_accept && (r_sel == BUF1);
  end

  assign in_ready   = w_in_ready;
  assign fifo_din   = in_data;
  assign sel        = r_sel;
  assign burst_done = r_burst_done;
  assign burst_buf  = r_burst_buf;
  assign burst_cnt  = r_burst_cnt;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_pingpong_wr_sched.sv
// Directed and randomized checks for pingpong_wr_sched with BURST_LEN=4 and an
// 8-bit burst counter so the random run exercises counter wrap.
module tb_pingpong_wr_sched;

  localparam int BL = 4;
  localparam int CW = 8;
  localparam int DW = 16;
  localparam int N_BURSTS = 1000;
  localparam int CYC_LIMIT = 60000;

  logic          wr_clk;
  logic          rst;
  logic          sched_en;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          fifo0_full, fifo1_full;
  logic          fifo0_prog_full, fifo1_prog_full;
  logic          fifo0_wr_en, fifo1_wr_en;
  logic [DW-1:0] fifo_din;
  logic          sel;
  logic          burst_done;
  logic          burst_buf;
  logic [CW-1:0] burst_cnt;
  logic          busy;

  int n_checks = 0;
  int n_err    = 0;

  pingpong_wr_sched #(
    .DATA_SIZE(DW),
    .BURST_LEN(BL),
    .CNT_W    (CW)
  ) dut (
    .wr_clk         (wr_clk),
    .rst            (rst),
    .sched_en       (sched_en),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .fifo0_full     (fifo0_full),
    .fifo1_full     (fifo1_full),
    .fifo0_prog_full(fifo0_prog_full),
    .fifo1_prog_full(fifo1_prog_full),
    .fifo0_wr_en    (fifo0_wr_en),
    .fifo1_wr_en    (fifo1_wr_en),
    .fifo_din       (fifo_din),
    .sel            (sel),
    .burst_done     (burst_done),
    .burst_buf      (burst_buf),
    .burst_cnt      (burst_cnt),
    .busy           (busy)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge wr_clk);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; sched_en = 1'b0; in_valid = 1'b1; in_data = '0;
    fifo0_full = 1'b0; fifo1_full = 1'b0;
    fifo0_prog_full = 1'b0; fifo1_prog_full = 1'b0;
    tick();
    tick();
    smp();
    check("rst_in_ready", in_ready, 0);
    check("rst_wr0", fifo0_wr_en, 0);
    check("rst_wr1", fifo1_wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_sel", sel, 0);
    check("rst_done", burst_done, 0);
    check("rst_buf", burst_buf, 0);
    check("rst_cnt", burst_cnt, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int       acc_cnt, bursts, cyc, n0;
    logic     pend, pend_buf, exp_buf, acc;
    logic [DW-1:0] cur;

    rst = 1'b1; sched_en = 1'b0; in_valid = 1'b0; in_data = '0;
    fifo0_full = 1'b0; fifo1_full = 1'b0;
    fifo0_prog_full = 1'b0; fifo1_prog_full = 1'b0;

    // Back-to-back bursts with no bubble at the buffer switch.
    do_reset();
    sched_en = 1'b1;
    in_data  = 16'h1000;
    smp();
    check("t1_idle_rdy", in_ready, 0);
    for (int i = 0; i <= 8; i++) begin
      tick();
      in_data = 16'h1000 + DW'(i);
      smp();
      check("t1_wr0", fifo0_wr_en, (i < 4 || i == 8));
      check("t1_wr1", fifo1_wr_en, (i >= 4 && i < 8));
      check("t1_din", fifo_din, 16'h1000 + DW'(i));
      check("t1_done", burst_done, (i == 4 || i == 8));
      if (i == 4) begin
        check("t1_buf_a", burst_buf, 0);
        check("t1_cnt_a", burst_cnt, 1);
      end
      if (i == 8) begin
        check("t1_buf_b", burst_buf, 1);
        check("t1_cnt_b", burst_cnt, 2);
      end
    end

    // prog_full on the next buffer forces WAIT until it is released.
    do_reset();
    sched_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) fifo1_prog_full = 1'b1;
      smp();
      check("t2_wr0", fifo0_wr_en, 1);
    end
    for (int w = 1; w <= 5; w++) begin
      tick();
      if (w == 5) fifo1_prog_full = 1'b0;
      smp();
      check("t2_wait_rdy", in_ready, 0);
      check("t2_wait_wr1", fifo1_wr_en, 0);
      check("t2_wait_busy", busy, 1);
      check("t2_wait_sel", sel, 1);
      if (w == 1) begin
        check("t2_done", burst_done, 1);
        check("t2_buf", burst_buf, 0);
      end
    end
    tick();
    smp();
    check("t2_resume_rdy", in_ready, 1);
    check("t2_resume_wr1", fifo1_wr_en, 1);

    // Full during a burst stalls without losing the word count.
    do_reset();
    sched_en = 1'b1;
    n0 = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      fifo0_full = (c >= 2 && c <= 4);
      in_data    = DW'(c);
      smp();
      check("t3_rdy", in_ready, !(c >= 2 && c <= 4));
      check("t3_wr0", fifo0_wr_en, !(c >= 2 && c <= 4) && c <= 7);
      check("t3_wr1", fifo1_wr_en, (c == 8));
      check("t3_done", burst_done, (c == 8));
      if (fifo0_wr_en) n0++;
    end
    check("t3_words", n0, 4);

    // sched_en dropped mid-burst: burst completes, then idle on the alternate buffer.
    do_reset();
    sched_en = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 2) sched_en = 1'b0;
      if (c == 6) sched_en = 1'b1;
      smp();
      check("t4_wr0", fifo0_wr_en, (c <= 4));
      check("t4_rdy", in_ready, (c <= 4));
      check("t4_busy", busy, (c <= 4));
      check("t4_done", burst_done, (c == 5));
      if (c >= 5) check("t4_sel", sel, 1);
    end
    tick();
    smp();
    check("t4_re_wr0", fifo0_wr_en, 0);
    check("t4_re_wr1", fifo1_wr_en, 1);

    // Reset in the middle of a burst.
    do_reset();
    sched_en = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      smp();
      check("t5_wr0", fifo0_wr_en, 1);
    end
    tick();
    rst = 1'b1;
    smp();
    check("t5_rst_rdy", in_ready, 0);
    check("t5_rst_wr0", fifo0_wr_en, 0);
    tick();
    rst = 1'b0;
    smp();
    check("t5_post_rdy", in_ready, 0);
    check("t5_post_sel", sel, 0);
    check("t5_post_cnt", burst_cnt, 0);
    check("t5_post_busy", busy, 0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      smp();
      check("t5_next_wr0", fifo0_wr_en, (c <= 4));
      check("t5_next_wr1", fifo1_wr_en, (c == 5));
      check("t5_next_done", burst_done, (c == 5));
    end

    // Randomized traffic against a word-index model: word k belongs to burst
    // k/BL, which goes to buffer (k/BL) mod 2.
    do_reset();
    sched_en = 1'b1;
    acc_cnt  = 0;
    bursts   = 0;
    pend     = 1'b0;
    pend_buf = 1'b0;
    cyc      = 0;
    cur      = DW'($urandom);
    while ((bursts < N_BURSTS || pend) && cyc < CYC_LIMIT) begin
      tick();
      cyc++;
      in_valid        = ($urandom_range(0, 9) < 7);
      fifo0_full      = ($urandom_range(0, 3) == 0);
      fifo1_full      = ($urandom_range(0, 3) == 0);
      fifo0_prog_full = ($urandom_range(0, 4) == 0);
      fifo1_prog_full = ($urandom_range(0, 4) == 0);
      in_data         = cur;
      smp();
      exp_buf = ((acc_cnt / BL) % 2) == 1;
      acc     = in_valid && in_ready;
      check("r_sel", sel, exp_buf);
      check("r_rdy_vs_full", in_ready && (exp_buf ? fifo1_full : fifo0_full), 0);
      check("r_wr0", fifo0_wr_en, acc && !exp_buf);
      check("r_wr1", fifo1_wr_en, acc && exp_buf);
      if (acc) check("r_din", fifo_din, cur);
      check("r_done", burst_done, pend);
      if (pend) check("r_buf", burst_buf, pend_buf);
      check("r_cnt", burst_cnt, bursts % (1 << CW));
      pend = 1'b0;
      if (acc) begin
        acc_cnt++;
        cur = DW'($urandom);
        if (acc_cnt % BL == 0) begin
          bursts++;
          pend     = 1'b1;
          pend_buf = exp_buf;
        end
      end
    end
    check("r_budget", (cyc < CYC_LIMIT), 1);
    check("r_bursts", bursts, N_BURSTS);
    check("r_final_cnt", burst_cnt, N_BURSTS % (1 << CW));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/pingpong_wr_sched.md
# pingpong_wr_sched

Write-side scheduler for the ping-pong buffer pair. It accepts one input stream and steers it into two write FIFO controllers (buffer 0 / buffer 1) in alternating bursts of exactly BURST_LEN words. Before each burst it checks that the target buffer's programmable-full level leaves room. It runs entirely in the write clock domain, sits between the data source and the two FIFO write ports, and reports burst completion to the read-side sequencer.

## Interface
- DATA_SIZE, 16, data width; matches the FIFO data width
- BURST_LEN, 256, words per burst; valid range 2..65535
- CNT_W, 16, width of burst_cnt

- wr_clk  in  1  write clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- sched_en  in  1  run enable; when low, the block stops at the next burst boundary
- in_valid  in  1  source has a word
- in_data  in  DATA_SIZE  source word
- in_ready  out  1  word is accepted this cycle when in_valid && in_ready
- fifo0_full, fifo1_full  in  1 each  full flag of each FIFO
- fifo0_prog_full, fifo1_prog_full  in  1 each  programmable-full flag of each FIFO
- fifo0_wr_en, fifo1_wr_en  out  1 each  write enable per FIFO
- fifo_din  out  DATA_SIZE  write data, shared by both FIFOs
- sel  out  1  current or next target buffer
- burst_done  out  1  one-cycle pulse after the last word of a burst
- burst_buf  out  1  buffer that the completed burst went to; valid with burst_done
- burst_cnt  out  CNT_W  number of completed bursts; wraps at 2^CNT_W
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, WAIT, WRITE. sel chooses the buffer for WAIT and WRITE.
- IDLE:
  - if sched_en is 1 and prog_full[sel] is 0, go to WRITE
  - if sched_en is 1 and prog_full[sel] is 1, go to WAIT
  - otherwise stay in IDLE
- WAIT: go to WRITE when prog_full[sel] is 0. sched_en is ignored; the buffer is already committed.
- WRITE:
  - in_ready = !full[sel]
  - accept = in_valid && in_ready
  - fifoN_wr_en = accept && (sel == N); fifo_din = in_data
  - on each accept, word_cnt increments
- Last word is the accept with word_cnt == BURST_LEN-1. On that accept:
  - word_cnt goes to 0, sel toggles, burst_done is pulsed, burst_buf = old sel, burst_cnt increments
  - next state: if sched_en is 0, IDLE; else if prog_full[new sel] is 0, WRITE; otherwise WAIT
- in_ready is 0 in IDLE and WAIT. Both wr_en outputs are 0 outside WRITE.
- Never both wr_en outputs at once. No wr_en while the target full flag is 1. No word is lost or duplicated.
- word_cnt width is clog2(BURST_LEN). burst_cnt wraps modulo 2^CNT_W.

## Timing
- Reset values: state IDLE, sel 0, word_cnt 0, burst_done 0, burst_buf 0, burst_cnt 0, busy 0. While rst is high, in_ready and both wr_en are 0.
- in_ready, fifoN_wr_en and fifo_din are combinational from the registered state/sel and the current in_valid, full and in_data. Latency from input to FIFO write port is zero.
- burst_done, burst_buf and burst_cnt are registered. They update in the cycle after the last accept.
- Buffer switch costs no bubble when the next buffer's prog_full is 0: the first word to the new buffer can be accepted in the cycle right after the last word.
- WAIT to WRITE: at least one cycle with in_ready = 0.
- IDLE to WRITE: one cycle after sched_en is sampled high.
- Full during a burst: in_ready drops in the same cycle; the block stalls with word_cnt held and resumes without loss.
- sched_en low during a burst: the burst finishes first. sched_en high again resumes on the alternate buffer.
- rst during a burst: abort immediately and load reset values. Partial data already in the FIFO is left there; clearing it is the system's job.

## Structure
- Shared package pingpong_pkg holds:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, WRITE=2'd2)
  - buffer index constants BUF0 / BUF1
- Single module with no sub-modules; per-buffer flags are muxed by sel.

## Test plan
- Reset, sched_en=1, in_valid held high, BURST_LEN=4, prog_full low -> wr_en pattern is fifo0 ×4, then fifo1 ×4 with no gap; burst_done pulses with burst_buf 0 then 1; burst_cnt 1 then 2.
- fifo1_prog_full=1 at the end of the buffer-0 burst, released 5 cycles later -> state WAIT, in_ready=0 for those 5 cycles, first fifo1 write one cycle after release.
- fifo0_full asserted on the 2nd word for 3 cycles -> no writes during those cycles, word_cnt holds at 1, burst still ends after exactly 4 words to fifo0.
- sched_en deasserted at word 2 of a burst -> words 3–4 still written, then IDLE with busy=0 and sel=1. Re-enable -> next burst goes to fifo1.
- rst pulsed at word 2 of a burst -> next cycle in_ready=0, sel=0, burst_cnt=0; next burst starts on fifo0.
- Random in_valid and full, 1000 bursts -> scoreboard shows data order preserved per buffer, exactly BURST_LEN words per burst, strict buffer alternation, burst_cnt = 1000 mod 2^CNT_W.
